key_expansion_ctrl: RTL
=======================

// Module: key_expansion_ctrl
// PURPOSE
//  Sequences the AES-128 key schedule: expands a 128-bit cipher key into round keys 0..NUM_ROUNDS,
//  one 32-bit word per cycle, through one internal operationG instance plus an XOR chain.
//  Presents each round key to the cipher core over a valid/ready handshake.
//  Generates the rcon sequence and owns the round counter.
//  Sits between the key register block and the AES round datapath.
// PARAMETERS
//  NUM_ROUNDS  10  number of expanded round keys after round 0; legal 1..10
// PORTS
//  clk        in   1    system clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  start      in   1    begin expansion of key_in; sampled in IDLE only
//  abort      in   1    synchronous abort; return to IDLE next cycle
//  key_in     in   128  cipher key; word0 = [127:96] ... word3 = [31:0]
//  rk_ready   in   1    consumer accepts round_key this cycle
//  rk_valid   out  1    round_key/round_num valid; held until rk_ready
//  round_key  out  128  current round key, same word order as key_in
//  round_num  out  4    index of round_key, 0..NUM_ROUNDS
//  busy       out  1    high in every state except IDLE
//  done       out  1    one-cycle pulse after the last round key is accepted
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; round_key=0, round_num=0, rcon=8'h01, widx=0.
//   Outputs after reset: rk_valid=0, busy=0, done=0.
//  States: IDLE, PRESENT, EXPAND, FINISH.
//  IDLE: on start=1, latch key_in into key_reg, set round_num=0 and rcon=01. Next state PRESENT.
//  PRESENT: rk_valid=1, round_key=key_reg.
//   - rk_ready=1 and round_num==NUM_ROUNDS -> FINISH.
//   - rk_ready=1 otherwise -> EXPAND with widx=0.
//   - rk_ready=0: hold; round_key and round_num must stay stable.
//  EXPAND: one word updated per cycle, in place, widx=0..3.
//   - widx0: w0 <= w0 ^ G(w3, {rcon,24'h0}), where G = RotWord/SubWord, i.e. operationG.
//   - widx1: w1 <= w1 ^ w0 (uses the new w0).
//   - widx2: w2 <= w2 ^ w1 (new w1).
//   - widx3: w3 <= w3 ^ w2 (new w2).
//   - After widx3: round_num++, rcon <= xtime(rcon), next state PRESENT.
//   - xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
//   - rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
//  FINISH: done=1 for exactly one cycle, then IDLE. key_reg retains the last round key.
//  Latency:
//   - start -> first rk_valid: 1 cycle.
//   - rk_ready accept -> next rk_valid: 5 cycles (4 EXPAND + 1 PRESENT entry).
//   - Total with rk_ready tied high: 1 + 5*NUM_ROUNDS + 2 cycles to done.
//  rk_valid is driven only in PRESENT. round_key is not updated while rk_valid=1.
//  start while busy is ignored; it is not queued.
//  abort in any non-IDLE state -> IDLE next cycle. abort beats rk_ready in the same cycle.
//   rk_valid drops, done is not pulsed, rcon is reset to 01.
//  start and abort both high in IDLE: abort wins; stay in IDLE.
//  rst asserted mid-expansion: immediate return to reset values; partial key discarded.
//  operationG is a single combinational instance; its input is always w3 of key_reg.
//   Its output is used only when state==EXPAND and widx==0.
// TESTING
//  T1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
//     rn0=key; rn1=a0fafe1788542cb123a339392a6c7605;
//     rn10=d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses once.
//  T2 Same key with rk_ready low for 7 cycles at rn3:
//     rk_valid stays high; round_key stable; sequence otherwise identical to T1.
//  T3 Zero key 0: rn1=62636363626363636263636362636363;
//     rn10=b4ef5bcb3e92e21123e951cf6f8f188e.
//  T4 abort while widx=2 in round 5:
//     IDLE next cycle, busy=0, no done; a fresh start reproduces the T1 sequence from rn0.
//  T5 rst pulsed mid-PRESENT:
//     all outputs 0 immediately; start pulse during busy -> ignored, sequence unchanged.
//  T6 NUM_ROUNDS=1:
//     rn0 then rn1, done after the second accept; cycle count = 1+5+2 with ready tied high.

Source files
------------

// File: rtl/key_expansion_ctrl.sv
// AES-128 key schedule sequencer: expands key_in into round keys 0..NUM_ROUNDS, one word per cycle.
// Latency: start -> first rk_valid 1 cycle; accept -> next rk_valid 5 cycles; done 1 cycle after last accept.
// Backpressure: round key held stable on rk_valid until rk_ready; no expansion work proceeds while stalled.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, abort      begin expansion (IDLE only) / return to IDLE next cycle (wins over everything)
//   key_in[127:0]     cipher key, word0 = [127:96] .. word3 = [31:0]
//   rk_ready          consumer accepts round_key this cycle
//   rk_valid          round_key/round_num valid (PRESENT only)
//   round_key[127:0]  current round key, same word order as key_in
//   round_num[3:0]    index of round_key, 0..NUM_ROUNDS
//   busy, done        not-IDLE flag / one-cycle pulse after the last round key is accepted
module key_expansion_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    EXPAND  = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b lives at bits [2047-8b -: 8]; {~b,3'b111} is exactly 2047-8b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [31:0] w [4];       // key_reg, w[0] is the most significant word
  logic [7:0]  rcon;
  logic [1:0]  widx;
  logic [31:0] g_rot;
  logic [31:0] g_out;

  // operationG: the single RotWord/SubWord/rcon instance, always fed from w3.
  // Its result only matters on the widx==0 step of EXPAND.
  always_comb begin
    g_rot = {w[3][23:0], w[3][31:24]};
    g_out = {sbox(g_rot[31:24]) ^ rcon,
             sbox(g_rot[23:16]),
             sbox(g_rot[15:8]),
             sbox(g_rot[7:0])};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. abort overrides every other condition outside IDLE,
  // and also suppresses start when both arrive together in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (rk_ready) begin
          state_nxt = (round_num == LAST_ROUND) ? FINISH : EXPAND;
        end
      end
      EXPAND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (widx == 2'd3) begin
          state_nxt = PRESENT;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    rk_valid = (state == PRESENT);
    busy     = (state != IDLE);
    done     = (state == FINISH);
  end

  assign round_key = {w[0], w[1], w[2], w[3]};

  // Key register, round counter, rcon and word index. The key is updated in
  // place, so each XOR step already sees the word written on the cycle before.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        w[i] <= 32'h0;
      end
      round_num <= 4'd0;
      rcon      <= 8'h01;
      widx      <= 2'd0;
    end else if (abort && (state != IDLE)) begin
      rcon <= 8'h01;
      widx <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            w[0]      <= key_in[127:96];
            w[1]      <= key_in[95:64];
            w[2]      <= key_in[63:32];
            w[3]      <= key_in[31:0];
            round_num <= 4'd0;
            rcon      <= 8'h01;
          end
        end
        PRESENT: begin
          if (rk_ready) begin
            widx <= 2'd0;
          end
        end
        EXPAND: begin
          case (widx)
            2'd0:    w[0] <= w[0] ^ g_out;
            2'd1:    w[1] <= w[1] ^ w[0];
            2'd2:    w[2] <= w[2] ^ w[1];
            default: w[3] <= w[3] ^ w[2];
          endcase
          widx <= widx + 2'd1;
          if (widx == 2'd3) begin
            round_num <= round_num + 4'd1;
            rcon      <= xtime(rcon);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
